// File: rtl/msk_gf4_mul_hpc3_pipe.sv
// msk_gf4_mul_hpc3_pipe: two-stage masked GF(4) multiplier / squarer,
// HPC3 style, d shares x N lanes, with valid/ready on data, rnd and out.
//
// Ports:
//   clk, nrst                 clock, async active-low reset (control only)
//   in_a0/in_a1, in_b0/in_b1  operand bit-planes, lane k share i at k*d+i
//   in_op                     0 = a*b, 1 = a^2 (no randomness consumed)
//   in_valid/in_ready         input handshake
//   rnd, rnd_valid/rnd_ready  fresh randomness, RND_LANE bits per lane
//   out0/out1                 result bit-planes, same layout as inputs
//   out_valid/out_ready       output handshake
//   busy                      any stage occupied
module msk_gf4_mul_hpc3_pipe #(
  parameter int d = 2,
  parameter int N = 1,
  localparam int RND_LANE = 2 * d * (d - 1)
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic [N*d-1:0]        in_a0,
  input  logic [N*d-1:0]        in_a1,
  input  logic [N*d-1:0]        in_b0,
  input  logic [N*d-1:0]        in_b1,
  input  logic                  in_op,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [N*RND_LANE-1:0] rnd,
  input  logic                  rnd_valid,
  output logic                  rnd_ready,
  output logic [N*d-1:0]        out0,
  output logic [N*d-1:0]        out1,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  busy
);

  localparam int NP    = d - 1;
  localparam int NPAIR = d * (d - 1) / 2;
  localparam int HALF  = RND_LANE / 2;

  typedef logic [1:0] gf4_t;

  // Normal-basis GF(4) product, {e1,e0} = e1*W + e0*W^2.
  function automatic gf4_t gf_mul(gf4_t x, gf4_t y);
    logic t;
    t = (x[1] ^ x[0]) & (y[1] ^ y[0]);
    return {(x[1] & y[1]) ^ t, (x[0] & y[0]) ^ t};
  endfunction

  // Index of the unordered share pair {i,j} in the rnd halves.
  function automatic int pair_off(int i, int j);
    int lo;
    int hi;
    lo = (i < j) ? i : j;
    hi = (i < j) ? j : i;
    return lo * d - lo * (lo + 1) / 2 + (hi - 1 - lo);
  endfunction

  // Slot of partner j among the d-1 partners of share i.
  function automatic int jx(int i, int j);
    return (j < i) ? j : j - 1;
  endfunction

  gf4_t [N-1:0][d-1:0]          a_d;
  gf4_t [N-1:0][d-1:0]          b_d;
  gf4_t [N-1:0][NPAIR-1:0]      r0;
  gf4_t [N-1:0][NPAIR-1:0]      r1;
  gf4_t [N-1:0][d-1:0][NP-1:0]  u_d;
  gf4_t [N-1:0][d-1:0][NP-1:0]  v_d;
  gf4_t [N-1:0][d-1:0][NP-1:0]  u_q;
  gf4_t [N-1:0][d-1:0][NP-1:0]  v_q;
  gf4_t [N-1:0][d-1:0]          a_q;
  gf4_t [N-1:0][d-1:0]          o_d;
  gf4_t [N-1:0][d-1:0]          o_q;
  logic                         op_q;

  logic s1_valid;
  logic s2_valid;
  logic s1_open;
  logic s2_open;
  logic xfer;
  logic s2_load;

  assign s2_open   = !s2_valid | out_ready;
  assign s1_open   = !s1_valid | s2_open;
  assign in_ready  = nrst & s1_open & (rnd_valid | in_op);
  assign xfer      = in_valid & in_ready;
  assign rnd_ready = xfer & !in_op;
  assign s2_load   = s1_valid & s2_open;
  assign out_valid = s2_valid;
  assign busy      = s1_valid | s2_valid;

  always_comb begin
    a_d = '0;
    b_d = '0;
    r0  = '0;
    r1  = '0;
    for (int k = 0; k < N; k++) begin
      for (int i = 0; i < d; i++) begin
        a_d[k][i] = {in_a1[k*d+i], in_a0[k*d+i]};
        b_d[k][i] = {in_b1[k*d+i], in_b0[k*d+i]};
      end
      for (int p = 0; p < NPAIR; p++) begin
        r0[k][p] = rnd[k*RND_LANE + 2*p +: 2];
        r1[k][p] = rnd[k*RND_LANE + HALF + 2*p +: 2];
      end
    end
  end

  // Stage 1: cross terms with fresh masks; the a_i*b_i term
  // is folded into the first partner slot only.
  always_comb begin
    u_d = '0;
    v_d = '0;
    for (int k = 0; k < N; k++) begin
      for (int i = 0; i < d; i++) begin
        for (int j = 0; j < d; j++) begin
          if (j != i) begin
            u_d[k][i][jx(i, j)] = in_op ? '0 :
              gf_mul(a_d[k][i],
                     r0[k][pair_off(i, j)] ^
                     ((jx(i, j) == 0) ? b_d[k][i] : '0))
              ^ r1[k][pair_off(i, j)];
            v_d[k][i][jx(i, j)] = in_op ? '0 :
              b_d[k][j] ^ r0[k][pair_off(i, j)];
          end
        end
      end
    end
  end

  // Stage 2: compress each share's terms using the registered a_i.
  always_comb begin
    o_d = '0;
    for (int k = 0; k < N; k++) begin
      for (int i = 0; i < d; i++) begin
        for (int j = 0; j < NP; j++) begin
          o_d[k][i] = o_d[k][i] ^ u_q[k][i][j]
                    ^ gf_mul(a_q[k][i], v_q[k][i][j]);
        end
        if (op_q) begin
          o_d[k][i] = {a_q[k][i][0], a_q[k][i][1]};
        end
      end
    end
  end

  always_comb begin
    out0 = '0;
    out1 = '0;
    for (int k = 0; k < N; k++) begin
      for (int i = 0; i < d; i++) begin
        out1[k*d+i] = o_q[k][i][1];
        out0[k*d+i] = o_q[k][i][0];
      end
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
    end else begin
      if (xfer) begin
        s1_valid <= 1'b1;
      end else if (s2_open) begin
        s1_valid <= 1'b0;
      end
      if (s2_open) begin
        s2_valid <= s1_valid;
      end
    end
  end

  // Share registers: enable only, never reset or cleared.
  always_ff @(posedge clk) begin
    if (xfer) begin
      u_q  <= u_d;
      v_q  <= v_d;
      a_q  <= a_d;
      op_q <= in_op;
    end
    if (s2_load) begin
      o_q <= o_d;
    end
  end

endmodule

// File: tb/tb_msk_gf4_mul_hpc3_pipe.sv
// tb_msk_gf4_mul_hpc3_pipe: directed and randomized bench for the
// masked GF(4) pipe, d=3 shares, 4 lanes, log/exp reference model.
module tb_msk_gf4_mul_hpc3_pipe;

  localparam int D  = 3;
  localparam int NL = 4;
  localparam int RL = 2 * D * (D - 1);

  logic            clk = 1'b0;
  logic            nrst;
  logic [NL*D-1:0] in_a0;
  logic [NL*D-1:0] in_a1;
  logic [NL*D-1:0] in_b0;
  logic [NL*D-1:0] in_b1;
  logic            in_op;
  logic            in_valid;
  logic            in_ready;
  logic [NL*RL-1:0] rnd;
  logic            rnd_valid;
  logic            rnd_ready;
  logic [NL*D-1:0] out0;
  logic [NL*D-1:0] out1;
  logic            out_valid;
  logic            out_ready;
  logic            busy;

  int errors = 0;
  int checks = 0;

  logic [7:0] cur_exp;
  logic [7:0] e1, e2, e3, e4;
  logic [7:0] eb [3];
  logic [7:0] r;
  logic [7:0] av, bv;
  logic [3:0] pr;
  logic [7:0] expq [$];
  int sent, got, cyc;
  bit pend;

  always #5 clk = ~clk;

  msk_gf4_mul_hpc3_pipe #(.d(D), .N(NL)) dut (
    .clk(clk), .nrst(nrst),
    .in_a0(in_a0), .in_a1(in_a1),
    .in_b0(in_b0), .in_b1(in_b1),
    .in_op(in_op), .in_valid(in_valid), .in_ready(in_ready),
    .rnd(rnd), .rnd_valid(rnd_valid), .rnd_ready(rnd_ready),
    .out0(out0), .out1(out1),
    .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy)
  );

  // GF(4)* is cyclic of order 3 generated by W: 1=11, W=10, W^2=01.
  function automatic int lg(logic [1:0] x);
    case (x)
      2'b11:   return 0;
      2'b10:   return 1;
      default: return 2;
    endcase
  endfunction

  function automatic logic [1:0] ex(int e);
    case (e % 3)
      0:       return 2'b11;
      1:       return 2'b10;
      default: return 2'b01;
    endcase
  endfunction

  function automatic logic [1:0] gmul(logic [1:0] x, logic [1:0] y);
    if (x == 2'b00 || y == 2'b00) return 2'b00;
    return ex(lg(x) + lg(y));
  endfunction

  function automatic logic [7:0] model(bit op, logic [7:0] a, logic [7:0] b);
    logic [7:0] res;
    res = '0;
    for (int k = 0; k < NL; k++) begin
      res[2*k +: 2] = op ? gmul(a[2*k +: 2], a[2*k +: 2])
                         : gmul(a[2*k +: 2], b[2*k +: 2]);
    end
    return res;
  endfunction

  function automatic logic [7:0] unmask();
    logic [7:0] res;
    res = '0;
    for (int k = 0; k < NL; k++) begin
      for (int i = 0; i < D; i++) begin
        res[2*k +: 2] = res[2*k +: 2] ^ {out1[k*D+i], out0[k*D+i]};
      end
    end
    return res;
  endfunction

  task automatic share(input logic [7:0] v,
                       output logic [NL*D-1:0] p0,
                       output logic [NL*D-1:0] p1);
    logic [1:0] acc;
    logic [1:0] s;
    p0 = '0;
    p1 = '0;
    for (int k = 0; k < NL; k++) begin
      acc = v[2*k +: 2];
      for (int i = 0; i < D - 1; i++) begin
        s = 2'($urandom);
        p1[k*D+i] = s[1];
        p0[k*D+i] = s[0];
        acc = acc ^ s;
      end
      p1[k*D+D-1] = acc[1];
      p0[k*D+D-1] = acc[0];
    end
  endtask

  task automatic offer(input bit op, input logic [7:0] a,
                       input logic [7:0] b);
    share(a, in_a0, in_a1);
    share(b, in_b0, in_b1);
    in_op    = op;
    in_valid = 1'b1;
    rnd      = {16'($urandom), $urandom};
    cur_exp  = model(op, a, b);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic drive_edge();
    @(posedge clk);
    #1;
  endtask

  initial begin
    nrst = 1'b0;
    in_a0 = '0; in_a1 = '0; in_b0 = '0; in_b1 = '0;
    in_op = 1'b0; rnd = '0; out_ready = 1'b0;
    in_valid = 1'b1;
    rnd_valid = 1'b1;

    // reset state with handshakes offered
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_in_ready", 32'(in_ready), 0);
    chk("rst_rnd_ready", 32'(rnd_ready), 0);
    in_valid = 1'b0;
    rnd_valid = 1'b0;
    nrst = 1'b1;

    // MUL a=W, b=W on lane 0 -> W^2
    drive_edge();
    out_ready = 1'b1;
    rnd_valid = 1'b1;
    offer(1'b0, {6'($urandom), 2'b10}, {6'($urandom), 2'b10});
    e1 = cur_exp;
    @(negedge clk);
    chk("mul_in_ready", 32'(in_ready), 1);
    chk("mul_rnd_ready", 32'(rnd_ready), 1);
    chk("mul_out_early", 32'(out_valid), 0);
    drive_edge();
    in_valid = 1'b0;
    rnd_valid = 1'b0;
    @(negedge clk);
    chk("mul_out_c1", 32'(out_valid), 0);
    chk("mul_rnd_once", 32'(rnd_ready), 0);
    chk("mul_busy", 32'(busy), 1);
    drive_edge();
    @(negedge clk);
    chk("mul_out_c2", 32'(out_valid), 1);
    r = unmask();
    chk("mul_res", 32'(r), 32'(e1));
    chk("mul_lane0", 32'(r[1:0]), 32'h1);

    // SQ without randomness
    drive_edge();
    offer(1'b1, {6'($urandom), 2'b11}, 8'($urandom));
    e2 = cur_exp;
    @(negedge clk);
    chk("sq1_in_ready", 32'(in_ready), 1);
    chk("sq1_rnd_ready", 32'(rnd_ready), 0);
    chk("sq1_out", 32'(out_valid), 0);
    drive_edge();
    offer(1'b1, {6'($urandom), 2'b10}, 8'($urandom));
    e3 = cur_exp;
    @(negedge clk);
    chk("sq2_in_ready", 32'(in_ready), 1);
    chk("sq2_rnd_ready", 32'(rnd_ready), 0);
    drive_edge();
    in_valid = 1'b0;
    @(negedge clk);
    chk("sq1_valid", 32'(out_valid), 1);
    r = unmask();
    chk("sq1_res", 32'(r), 32'(e2));
    chk("sq1_lane0", 32'(r[1:0]), 32'h3);
    drive_edge();
    @(negedge clk);
    chk("sq2_valid", 32'(out_valid), 1);
    r = unmask();
    chk("sq2_res", 32'(r), 32'(e3));
    chk("sq2_lane0", 32'(r[1:0]), 32'h1);

    // backpressure: capacity two, then ordered release
    drive_edge();
    out_ready = 1'b0;
    rnd_valid = 1'b1;
    offer(1'b0, 8'($urandom), 8'($urandom));
    eb[0] = cur_exp;
    @(negedge clk);
    chk("bp_t1_ready", 32'(in_ready), 1);
    drive_edge();
    offer(1'b1, 8'($urandom), 8'($urandom));
    eb[1] = cur_exp;
    @(negedge clk);
    chk("bp_t2_ready", 32'(in_ready), 1);
    drive_edge();
    offer(1'b0, 8'($urandom), 8'($urandom));
    eb[2] = cur_exp;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("bp_t3_blocked", 32'(in_ready), 0);
      chk("bp_busy", 32'(busy), 1);
      chk("bp_hold_valid", 32'(out_valid), 1);
      drive_edge();
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_pushpop_ready", 32'(in_ready), 1);
    chk("bp_res0", 32'(unmask()), 32'(eb[0]));
    drive_edge();
    in_valid = 1'b0;
    rnd_valid = 1'b0;
    @(negedge clk);
    chk("bp_valid1", 32'(out_valid), 1);
    chk("bp_res1", 32'(unmask()), 32'(eb[1]));
    drive_edge();
    @(negedge clk);
    chk("bp_valid2", 32'(out_valid), 1);
    chk("bp_res2", 32'(unmask()), 32'(eb[2]));
    drive_edge();
    @(negedge clk);
    chk("bp_drained", 32'(out_valid), 0);
    chk("bp_idle", 32'(busy), 0);

    // randomness starvation
    drive_edge();
    offer(1'b0, 8'($urandom), 8'($urandom));
    e4 = cur_exp;
    @(negedge clk);
    chk("st_in_ready", 32'(in_ready), 0);
    chk("st_rnd_ready", 32'(rnd_ready), 0);
    chk("st_busy", 32'(busy), 0);
    drive_edge();
    @(negedge clk);
    chk("st_busy2", 32'(busy), 0);
    chk("st_out", 32'(out_valid), 0);
    drive_edge();
    rnd_valid = 1'b1;
    @(negedge clk);
    chk("st_go_ready", 32'(in_ready), 1);
    chk("st_go_rnd", 32'(rnd_ready), 1);
    drive_edge();
    in_valid = 1'b0;
    rnd_valid = 1'b0;
    @(negedge clk);
    chk("st_busy3", 32'(busy), 1);
    drive_edge();
    @(negedge clk);
    chk("st_valid", 32'(out_valid), 1);
    chk("st_res", 32'(unmask()), 32'(e4));

    // reset with both stages full
    drive_edge();
    out_ready = 1'b0;
    rnd_valid = 1'b1;
    offer(1'b0, 8'($urandom), 8'($urandom));
    drive_edge();
    offer(1'b1, 8'($urandom), 8'($urandom));
    drive_edge();
    in_valid = 1'b0;
    rnd_valid = 1'b0;
    @(negedge clk);
    chk("rm_full_busy", 32'(busy), 1);
    chk("rm_full_valid", 32'(out_valid), 1);
    #2;
    nrst = 1'b0;
    #1;
    chk("rm_async_valid", 32'(out_valid), 0);
    chk("rm_async_busy", 32'(busy), 0);
    drive_edge();
    chk("rm_held_busy", 32'(busy), 0);
    @(negedge clk);
    nrst = 1'b1;
    out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("rm_no_output", 32'(out_valid), 0);
    end

    // exhaustive pairs per lane, MUL/SQ interleaved, random stalls
    sent = 0;
    got = 0;
    cyc = 0;
    pend = 1'b0;
    expq.delete();
    drive_edge();
    while ((sent < 64 || expq.size() != 0) && cyc < 2000) begin
      if (!pend) begin
        if (sent < 64 && $urandom_range(3) != 0) begin
          for (int k = 0; k < NL; k++) begin
            pr = 4'((sent / 2 + 4 * k) % 16);
            av[2*k +: 2] = pr[3:2];
            bv[2*k +: 2] = pr[1:0];
          end
          offer(1'(sent % 2), av, bv);
          pend = 1'b1;
        end else begin
          in_valid = 1'b0;
        end
      end
      rnd_valid = ($urandom_range(7) != 0);
      out_ready = 1'($urandom_range(1));
      @(negedge clk);
      if (out_valid && out_ready) begin
        if (expq.size() == 0) begin
          chk("rnd_spurious_out", 32'(out_valid), 0);
        end else begin
          chk("rnd_res", 32'(unmask()), 32'(expq.pop_front()));
          got++;
        end
      end
      if (in_valid && in_ready) begin
        chk("rnd_rnd_ready", 32'(rnd_ready), 32'(!in_op));
        expq.push_back(cur_exp);
        sent++;
        pend = 1'b0;
      end
      drive_edge();
      cyc++;
    end
    in_valid = 1'b0;
    chk("rnd_sent", 32'(sent), 64);
    chk("rnd_got", 32'(got), 64);
    chk("rnd_queue_empty", 32'(expq.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/msk_gf4_mul_hpc3_pipe.md
# msk_gf4_mul_hpc3_pipe

Pipelined, multi-lane masked GF(4) multiplier in the HPC3 style, with d shares and N independent lanes. It adds valid/ready flow control on data, randomness and output, internal handling of the delayed `a` operand, and a per-transaction linear squaring mode that consumes no randomness. It is the GF(4) stage of the masked inversion datapath and sits between the GF(16) decomposition and recombination stages. It supersedes the free-running single-lane gadget wherever stalls can occur.

## Interface
- `d`, default 2: number of shares; legal range d ≥ 2.
- `N`, default 1: number of parallel GF(4) lanes.
- `RND_LANE`, derived, 2·d·(d−1): random bits consumed per lane per MUL transaction.
- `clk` in 1: single clock. All state updates on the rising edge.
- `nrst` in 1: reset, asynchronous and active-low. Clears control state only.
- `in_a0`, `in_a1` in N·d: bit-planes of operand a. Lane k, share i is at bit k·d+i; `a1` is the high bit.
- `in_b0`, `in_b1` in N·d: bit-planes of operand b, same layout. Ignored in SQ mode.
- `in_op` in 1: 0 = MUL (a·b), 1 = SQ (a²). One op applies to all lanes of the transaction.
- `in_valid` in 1, `in_ready` out 1: input handshake.
- `rnd` in N·RND_LANE: fresh randomness. Lane k uses slice k·RND_LANE +: RND_LANE. Lower half is r0, upper half is r1.
- `rnd_valid` in 1, `rnd_ready` out 1: randomness handshake.
- `out0`, `out1` out N·d: result bit-planes, same layout as the inputs.
- `out_valid` out 1, `out_ready` in 1: output handshake.
- `busy` out 1: high when any pipeline stage holds a transaction.

## Operation
- **GF(4) encoding.** Normal basis: {e1,e0} = e1·W + e0·W², with W² = W + 1.
  - 1 = 11, W = 10, W² = 01.
  - Squaring is a bit swap.
- **Random pair indexing.** For share pair i<j: offset = i·d − i(i+1)/2 + (j−1−i). r0 pair = r0[2·offset +: 2], r1 pair likewise. Pair (j,i) uses the same bits as (i,j).
- **MUL, per lane, share i, each j≠i.** Let j2 = j if j<i, else j−1.
  - u_ij = a_i·(r0_ij ⊕ (j2==0 ? b_i : 0)) ⊕ r1_ij, registered in stage 1.
  - v_ij = b_j ⊕ r0_ij, registered in stage 1.
  - a_i is registered in stage 1 alongside u and v; this register provides the delayed a.
  - Stage 2 computes out_i = ⊕_j (u_ij ⊕ a_i_reg·v_ij) and registers it.
  - Unmasked ⊕_i out_i = a·b.
- **SQ.** out_i = swap(a_i) sharewise, carried through the same two stages. The u and v registers hold zero (no randomness involved). Unmasked result = a².
- **Handshakes.**
  - s2_open = !s2_valid | out_ready.
  - s1_open = !s1_valid | s2_open.
  - in_ready = nrst & s1_open & (rnd_valid | in_op).
  - Input transfer: in_valid & in_ready.
  - rnd_ready = in_valid & in_ready & !in_op. Each rnd word is used for exactly one MUL transaction. SQ transfers never assert rnd_ready.
  - in_ready may depend on in_op; producers must hold in_op stable while in_valid is high.
- **Stage movement.**
  - Stage 1 loads on an input transfer. It holds its contents while !s2_open.
  - Stage 2 loads from stage 1 when s1_valid & s2_open. It holds while out_valid & !out_ready.
  - Datapath registers use enables only; they are never cleared.
- **Security.** Share registers have no reset and no mux with constants. Held data is re-registered unchanged, so no recombination occurs during stalls.

## Timing
- Latency: 2 cycles from input transfer to out_valid, for both ops. Throughput: 1 transaction per cycle with out_ready=1 and rnd_valid=1.
- Capacity: 2 transactions. With out_ready=0, exactly two are accepted, then in_ready drops.
- Simultaneous output pop and input push when full: both occur in the same cycle; no bubble.
- Reset values: s1_valid=0, s2_valid=0, out_valid=0, busy=0. in_ready=0 and rnd_ready=0 while nrst=0.
- out0/out1 are undefined until the first output; compare only while out_valid=1.
- Reset mid-operation: valid flags clear immediately. In-flight transactions are dropped; none emerge after release.
- rnd_valid low with a MUL pending: no transfer and no stall of downstream stages.

## Test plan
- **MUL, d=2, N=1.**
  - Stimulus: a shares (11, 01), i.e. a=10; b shares (01, 11), i.e. b=10; random rnd.
  - Required: unmasked output 01 exactly 2 cycles after transfer; rnd_ready pulses once.
- **SQ.**
  - Stimulus: a=11, then a=10, with rnd_valid=0.
  - Required: unmasked outputs 11 then 01; rnd_ready never asserted; in_ready stays high.
- **Backpressure.**
  - Stimulus: out_ready=0, three back-to-back transfers offered.
  - Required: two accepted; in_ready=0 on the third. Raising out_ready releases results in order, none lost or duplicated.
- **Randomness starvation.**
  - Stimulus: rnd_valid=0 with a MUL offered.
  - Required: no transfer, busy unchanged. Raising rnd_valid completes the transfer on that cycle.
- **Reset mid-operation.**
  - Stimulus: both stages full, nrst pulsed low.
  - Required: out_valid and busy fall asynchronously; no output appears after release until new input.
- **Exhaustive, N=4, d=3.**
  - Stimulus: all 16 (a,b) pairs per lane with random shares and rnd; MUL and SQ interleaved at full rate; random out_ready.
  - Required: every unmasked result matches the GF(4) table.
